// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-side line responder.
package mem_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_BITS      = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFFSET_BITS    = WORD_BITS + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_e;

    // line_addr sits in the MSBs so FIFO match logic can compare the top ADDR_W bits.
    typedef struct packed {
        logic [ADDR_W-1:0] line_addr;
        logic              prefetch;
    } mem_req_t;

    // Clear the byte-within-line offset of an address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Small request FIFO with full/empty flags and a compare port over all live entries.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CMP_W = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    input  logic [CMP_W-1:0] match_key,
    output logic             match
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = slot_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Compare the key against every occupied slot, walking from the head.
    always_comb begin
        match = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (slot_q[rd_ptr_q + PTR_W'(k)][W-1 -: CMP_W] == match_key)) begin
                match = 1'b1;
            end
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) slot_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory model serving demand and prefetch line fills as fixed-latency word bursts.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LINES = 256,
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic                 req_prefetch,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_W-1:0]    resp_data,
    output logic [WORD_BITS-1:0] resp_word,
    output logic                 resp_last,
    output logic                 resp_prefetch,
    output logic [ADDR_W-1:0]    resp_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned LINE_BITS = $clog2(MEM_LINES);
    localparam int unsigned MIDX_W    = LINE_BITS + WORD_BITS;
    localparam int unsigned MEM_WORDS = MEM_LINES * WORDS_PER_LINE;
    localparam int unsigned LAT_W     = $clog2(LATENCY);
    localparam int unsigned REQ_W     = $bits(mem_req_t);

    state_e                state_q, state_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]     cur_line_q, cur_line_d;
    logic                  cur_pf_q, cur_pf_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0]     resp_data_q, resp_data_d;
    logic [WORD_BITS-1:0]  resp_word_q, resp_word_d;
    logic                  resp_last_q, resp_last_d;
    logic                  resp_pf_q, resp_pf_d;
    logic [ADDR_W-1:0]     resp_addr_q, resp_addr_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    mem_req_t              push_req, dmd_head, pf_head;
    logic                  dmd_full, dmd_empty, dmd_match, dmd_push, dmd_pop;
    logic                  pf_full, pf_empty, pf_match, pf_push, pf_pop, pf_drop;
    logic [ADDR_W-1:0]     req_line;
    logic                  req_fire, pf_dup;

    // Written words override the elaboration-time image (word i holds i).
    logic [WORD_W-1:0]     mem_q [MEM_WORDS];
    logic [MEM_WORDS-1:0]  written_q = '0;
    logic [MIDX_W-1:0]     wr_idx, rd_idx;
    logic [WORD_BITS-1:0]  load_word;
    logic [WORD_W-1:0]     rd_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[OFFSET_BITS-1:0], wr_addr[1:0], wr_addr[ADDR_W-1:MIDX_W+2]};

    assign req_line  = line_align(req_addr);
    assign req_ready = req_prefetch || !dmd_full;
    assign req_fire  = req_valid && req_ready;
    assign pf_dup    = ((state_q != IDLE) && (cur_line_q == req_line)) || dmd_match || pf_match;
    assign dmd_push  = req_fire && !req_prefetch;
    assign pf_push   = req_fire && req_prefetch && !pf_dup && !pf_full;
    assign pf_drop   = req_fire && req_prefetch && !pf_dup && pf_full;
    assign push_req  = '{line_addr: req_line, prefetch: req_prefetch};

    req_fifo #(.DEPTH(QDEPTH), .W(REQ_W), .CMP_W(ADDR_W)) u_dmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dmd_push),
        .push_data (push_req),
        .pop       (dmd_pop),
        .head      (dmd_head),
        .full      (dmd_full),
        .empty     (dmd_empty),
        .match_key (req_line),
        .match     (dmd_match)
    );

    req_fifo #(.DEPTH(QDEPTH), .W(REQ_W), .CMP_W(ADDR_W)) u_pf_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pf_push),
        .push_data (push_req),
        .pop       (pf_pop),
        .head      (pf_head),
        .full      (pf_full),
        .empty     (pf_empty),
        .match_key (req_line),
        .match     (pf_match)
    );

    assign wr_idx    = wr_addr[2 +: MIDX_W];
    assign load_word = (state_q == BURST) ? resp_word_q + WORD_BITS'(1) : '0;
    assign rd_idx    = {cur_line_q[OFFSET_BITS +: LINE_BITS], load_word};

    // Word fetched for the next beat; a store landing on the same edge is forwarded.
    always_comb begin
        rd_data = written_q[rd_idx] ? mem_q[rd_idx] : WORD_W'(rd_idx);
        if (wr_en && (wr_idx == rd_idx)) rd_data = wr_data;
    end

    // Stores commit every edge, independent of reset and of the fill engine.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx]     <= wr_data;
            written_q[wr_idx] <= 1'b1;
        end
    end

    // Fill engine next-state: arbitrate in IDLE, count latency, stream beats.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        cur_line_d   = cur_line_q;
        cur_pf_d     = cur_pf_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_word_d  = resp_word_q;
        resp_last_d  = resp_last_q;
        resp_pf_d    = resp_pf_q;
        resp_addr_d  = resp_addr_q;
        dmd_pop      = 1'b0;
        pf_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!dmd_empty || !pf_empty) begin
                    dmd_pop    = !dmd_empty;
                    pf_pop     = dmd_empty;
                    cur_line_d = dmd_empty ? pf_head.line_addr : dmd_head.line_addr;
                    cur_pf_d   = dmd_empty ? pf_head.prefetch : dmd_head.prefetch;
                    lat_cnt_d  = LAT_W'(LATENCY - 2);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d      = BURST;
                    resp_valid_d = 1'b1;
                    resp_word_d  = load_word;
                    resp_data_d  = rd_data;
                    resp_last_d  = (load_word == '1);
                    resp_pf_d    = cur_pf_q;
                    resp_addr_d  = cur_line_q;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            BURST: begin
                if (resp_ready) begin
                    if (resp_last_q) begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b0;
                        resp_last_d  = 1'b0;
                    end else begin
                        resp_word_d = load_word;
                        resp_data_d = rd_data;
                        resp_last_d = (load_word == '1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of prefetches discarded for lack of queue space.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (pf_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Engine and output registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            cur_line_q   <= '0;
            cur_pf_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_word_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_pf_q    <= 1'b0;
            resp_addr_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            cur_line_q   <= cur_line_d;
            cur_pf_q     <= cur_pf_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_word_q  <= resp_word_d;
            resp_last_q  <= resp_last_d;
            resp_pf_q    <= resp_pf_d;
            resp_addr_q  <= resp_addr_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_word     = resp_word_q;
    assign resp_last     = resp_last_q;
    assign resp_prefetch = resp_pf_q;
    assign resp_addr     = resp_addr_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: expected beats queued at request time.
module tb_mem_line_responder;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  word;
        logic        last;
        logic        pf;
        logic [31:0] addr;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_prefetch;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_word;
    logic        resp_last;
    logic        resp_prefetch;
    logic [31:0] resp_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] drop_cnt;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned cyc    = 0;
    int unsigned acc_cyc;
    int unsigned w0_hs_cyc;
    int unsigned last_hs_cyc;
    int          stall_word = -1;
    int          stall_left = 0;
    logic [31:0] model [1024];
    beat_t       sb [$];
    beat_t       exp_b;

    mem_line_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_prefetch  (req_prefetch),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_word     (resp_word),
        .resp_last     (resp_last),
        .resp_prefetch (resp_prefetch),
        .resp_addr     (resp_addr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .drop_cnt      (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue the four beats a fill of this address should produce.
    task automatic push_fill(input logic [31:0] addr, input logic pf);
        for (int w = 0; w < 4; w++) begin
            beat_t b;
            int unsigned idx;
            idx    = ((addr >> 4) % 256) * 4 + w;
            b.data = model[idx];
            b.word = 2'(w);
            b.last = (w == 3);
            b.pf   = pf;
            b.addr = addr & ~32'hF;
            sb.push_back(b);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic pf, input bit expect_fill);
        int n;
        req_valid    = 1'b1;
        req_addr     = addr;
        req_prefetch = pf;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_eq("req_accept_timeout", 64'(req_ready), 64'(1));
        if (pf) check_eq("pf_req_ready", 64'(req_ready), 64'(1));
        if (expect_fill) push_fill(addr, pf);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        model[(addr >> 2) % 1024] = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, 64'(resp_valid), 64'(0));
    endtask

    // Back-pressure generator: stall a chosen beat for a set number of cycles.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (resp_valid && (int'(resp_word) == stall_word) && stall_left > 0) begin
                resp_ready = 1'b0;
                stall_left--;
            end else begin
                resp_ready = 1'b1;
            end
        end
    end

    // Beat monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 64'(resp_valid), 64'(0));
            end else begin
                exp_b = sb[0];
                check_eq("beat_data", 64'(resp_data), 64'(exp_b.data));
                check_eq("beat_word", 64'(resp_word), 64'(exp_b.word));
                check_eq("beat_last", 64'(resp_last), 64'(exp_b.last));
                check_eq("beat_pf",   64'(resp_prefetch), 64'(exp_b.pf));
                check_eq("beat_addr", 64'(resp_addr), 64'(exp_b.addr));
                if (resp_ready) begin
                    void'(sb.pop_front());
                    if (exp_b.word == 2'd0) w0_hs_cyc = cyc;
                    if (exp_b.last) last_hs_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) model[i] = 32'(i);
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_prefetch = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("rst_req_ready",  64'(req_ready),  64'(1));
        check_eq("rst_drop_cnt",   64'(drop_cnt),   64'(0));
        check_eq("rst_resp_data",  64'(resp_data),  64'(0));
        check_eq("rst_resp_last",  64'(resp_last),  64'(0));

        // Single demand fill with first-beat latency.
        send_req(32'h40, 1'b0, 1'b1);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_beat_latency", 64'(cyc - acc_cyc), 64'(8));
        wait_drain("single_fill");
        check_eq("single_span", 64'(last_hs_cyc - w0_hs_cyc + 1), 64'(4));

        // Back-pressure on beat 1 for three cycles.
        stall_word = 1;
        stall_left = 3;
        send_req(32'h40, 1'b0, 1'b1);
        wait_drain("backpressure");
        check_eq("stall_span", 64'(last_hs_cyc - w0_hs_cyc + 1), 64'(7));
        stall_word = -1;

        // Demand overtakes a queued prefetch but not an in-flight one.
        send_req(32'h100, 1'b1, 1'b1);
        send_req(32'h200, 1'b0, 1'b1);
        send_req(32'h300, 1'b1, 1'b1);
        wait_drain("priority");

        // Prefetch overflow counts a drop; duplicates are silently absorbed.
        send_req(32'h00, 1'b0, 1'b1);
        send_req(32'h10, 1'b1, 1'b1);
        send_req(32'h20, 1'b1, 1'b1);
        send_req(32'h30, 1'b1, 1'b1);
        send_req(32'h50, 1'b1, 1'b1);
        send_req(32'h60, 1'b1, 1'b0);
        check_eq("drop_after_full", 64'(drop_cnt), 64'(1));
        send_req(32'h20, 1'b1, 1'b0);
        check_eq("drop_after_dup_queued", 64'(drop_cnt), 64'(1));
        send_req(32'h00, 1'b1, 1'b0);
        check_eq("drop_after_dup_inflight", 64'(drop_cnt), 64'(1));
        wait_drain("drop_dup");

        // Store then fill, and the same line through the wrapped address.
        store(32'h44, 32'hDEADBEEF);
        send_req(32'h40, 1'b0, 1'b1);
        wait_drain("store_fill");
        send_req(32'h40 + 256 * 16, 1'b0, 1'b1);
        wait_drain("wrap_fill");

        // Reset after beat 1 with another demand queued behind it.
        send_req(32'hC0, 1'b0, 1'b1);
        send_req(32'hD0, 1'b0, 1'b0);
        n = 0;
        while (!(resp_valid && resp_ready && resp_word == 2'd1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_beat1", 64'(n >= 60), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_eq("midrst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("midrst_drop_cnt",   64'(drop_cnt),   64'(0));
        check_eq("midrst_req_ready",  64'(req_ready),  64'(1));
        send_req(32'h80, 1'b0, 1'b1);
        wait_drain("post_reset_fill");
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the direct-mapped cache and prefetcher. It serves line-fill requests (demand misses and prefetches) issued by the cache controller.
- It models main memory as a word array with a fixed access latency and a word-by-word burst return.
- Demand fills take priority over queued prefetches. Single-word write-through stores from the cache are applied immediately.
- Instantiated inside main, between the cache and the top-level memory image.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, data word width.
- WORDS_PER_LINE, 4, words per cache line (power of 2).
- MEM_LINES, 256, lines in the memory model (power of 2). Index wraps modulo MEM_LINES.
- LATENCY, 8, cycles from request acceptance to first beat when idle (>=2).
- QDEPTH, 4, depth of each request FIFO (power of 2).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, line-fill request valid.
- req_ready, out, 1, request accepted when req_valid & req_ready.
- req_addr, in, ADDR_W, byte address; offset bits ignored.
- req_prefetch, in, 1, 1 = prefetch, 0 = demand.
- resp_valid, out, 1, beat valid.
- resp_ready, in, 1, cache accepts beat.
- resp_data, out, WORD_W, beat data.
- resp_word, out, log2(WORDS_PER_LINE), word index within line.
- resp_last, out, 1, final beat of line.
- resp_prefetch, out, 1, beat belongs to a prefetch fill.
- resp_addr, out, ADDR_W, line-aligned address of the fill.
- wr_en, in, 1, single-word store.
- wr_addr, in, ADDR_W, store byte address.
- wr_data, in, WORD_W, store data.
- drop_cnt, out, 16, prefetches dropped (saturating).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effect: both FIFOs flushed, FSM to IDLE, counter cleared. All outputs 0 except req_ready=1. Reset mid-burst abandons the burst with no further beats. Memory contents are not affected by rst.
- Memory initialisation: word i = i (WORD_W-wide) at elaboration.
- Address split: word offset = addr[log2(WPL)+1:2]; line index = next log2(MEM_LINES) bits; upper bits ignored (wrap).
- Queues: two FIFOs, demand and prefetch, each QDEPTH entries holding the line address.
- req_ready = !demand_full when req_prefetch=0. req_ready = 1 always when req_prefetch=1.
- Prefetch while prefetch FIFO full: accepted and discarded; drop_cnt increments and saturates at 0xFFFF.
- Duplicate suppression: a prefetch whose line equals the in-flight line or any queued entry is accepted and discarded without counting.
- FSM states:
  - IDLE: if demand FIFO non-empty, pop it; else if prefetch FIFO non-empty, pop it. Go to WAIT with lat_cnt loaded.
  - WAIT: count down. Enter BURST so that the first beat of a request accepted into an empty, idle responder is valid exactly LATENCY cycles after the accepting edge.
  - BURST: present beat k (k = 0..WPL-1, ascending). Outputs hold while resp_valid & !resp_ready. Advance k on handshake. On handshake of the last beat, go to IDLE. The next request may start in that same IDLE cycle (one bubble between lines).
- Arbitration: selection happens only in IDLE; an in-flight prefetch is never preempted. Simultaneous enqueue and pop on the same FIFO is legal and keeps the count unchanged.
- Stores: wr_en writes the word at the clock edge, at any time, with no back-pressure. A beat presented in the cycle of the write shows old data; later beats show new data.

Decomposition:
- Shared package mem_pkg:
  - WORD_W, ADDR_W, WORDS_PER_LINE and derived OFFSET_BITS / WORD_BITS.
  - State enum {IDLE, WAIT, BURST}.
  - Request struct {line_addr, prefetch}.
- One sub-module, req_fifo (parameterised depth/width, with full/empty flags and a match-compare port for duplicate checking). It is instantiated twice.

Test Plan:
- Single demand fill: reset; demand req 0x40, resp_ready=1 -> beats at +8..+11 cycles with data 16,17,18,19 and resp_word 0..3. resp_last on beat 3, resp_prefetch=0, resp_addr=0x40.
- Back-pressure: same request with resp_ready low for 3 cycles on beat 1 -> data 17 held stable. Total burst spans 7 cycles; no beat lost or duplicated.
- Priority: prefetch 0x100 and, while it is in WAIT, demand 0x200 plus prefetch 0x300 -> fills complete in order 0x100, 0x200, 0x300. Beat 0 data 64, 128, 192 respectively.
- Drop and duplicate: demand 0x0 in flight; 4 prefetches 0x10,0x20,0x30,0x50 fill the FIFO; then prefetch 0x60 -> drop_cnt=1. Then prefetch 0x20 -> drop_cnt stays 1. Both req_ready=1.
- Store then fill: wr_en at 0x44 data 0xDEADBEEF, then demand 0x40 -> beat 1 = 0xDEADBEEF. Address 0x40+MEM_LINES*16 returns the same line (wrap).
- Reset mid-burst: assert rst after beat 1 of a fill -> next cycle resp_valid=0, queues empty, drop_cnt=0. A new demand 0x80 completes normally with data 32..35.
